// File: rtl/chan_arb_mux.sv
// Registered N-channel valid/ready mux with fixed-select and round-robin modes.
// Optional packet lock (in_last/out_last) is enabled by defining CHAN_ARB_MUX_LOCK_EN.
module chan_arb_mux #(
    parameter int WIDTH = 3,
    parameter int NCH = 8,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
`ifdef CHAN_ARB_MUX_LOCK_EN
    input  logic [NCH-1:0]        in_last,
    output logic                  out_last,
`endif
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] chan_data [NCH];
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  idx;
    logic             grant_valid;
    logic             load;
    logic             accept;

`ifdef CHAN_ARB_MUX_LOCK_EN
    logic             locked;
    logic [SELW-1:0]  lock_ch;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign load   = !out_valid | out_ready;
    assign accept = rst_n & load & grant_valid;

    // Scan from farthest to nearest so the channel closest after ptr wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        if (!mode) begin
            if (int'(sel) < NCH) begin
                if (in_valid[sel]) begin
                    grant       = sel;
                    grant_valid = 1'b1;
                end
            end
`ifdef CHAN_ARB_MUX_LOCK_EN
        end else if (locked) begin
            grant       = lock_ch;
            grant_valid = in_valid[lock_ch];
`endif
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                idx = SELW'((int'(ptr) + k) % NCH);
                if (in_valid[idx]) begin
                    grant       = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = accept && (grant == SELW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH - 1);
`ifdef CHAN_ARB_MUX_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= chan_data[grant];
                out_ch   <= grant;
                if (mode) begin
                    ptr <= grant;
                end
`ifdef CHAN_ARB_MUX_LOCK_EN
                out_last <= in_last[grant];
                if (mode) begin
                    locked  <= !in_last[grant];
                    lock_ch <= grant;
                end
`endif
            end
        end
    end

endmodule

// File: doc/chan_arb_mux.md
# chan_arb_mux

Parametrised, registered N-channel, WIDTH-bit multiplexer with a valid/ready handshake on every input channel and on the output. Supports two modes: fixed select (a direct successor of the 8:1 combinational mux) and round-robin arbitration across requesting channels. It sits between several producer blocks and a single downstream consumer. It provides a one-cycle registered stage and full-throughput back-pressure.

## Interface
- WIDTH, 3, data bits per channel
- NCH, 8, number of input channels (2..16)
- SELW, $clog2(NCH), width of the select and channel-ID fields (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel selected in fixed mode
- out_data  output  WIDTH  registered selected data
- out_ch  output  SELW  channel index of the beat in out_data
- out_valid  output  1  output register occupied
- out_ready  input  1  consumer accepts the beat

## Operation
- One output register (out_data, out_ch, out_valid).
  - load = !out_valid | out_ready.
- Grant is computed combinationally each cycle:
  - Fixed mode: grant = sel when sel < NCH and in_valid[sel]; otherwise no grant.
  - Round-robin mode: grant = first i with in_valid[i], scanning ptr+1, ptr+2, … modulo NCH, where ptr is the last granted channel.
- in_ready[i] = load & grant_valid & (grant == i). All other channels see in_ready = 0.
- On load & grant_valid:
  - out_data <= in_data[grant]
  - out_ch <= grant
  - out_valid <= 1
  - ptr <= grant (round-robin mode only; ptr is unchanged in fixed mode)
- On load & !grant_valid: out_valid <= 0. Data and ch hold their previous values.
- Held beat: while out_valid & !out_ready, out_data and out_ch are stable and every in_ready is 0.
- Wrap-around: ptr = NCH-1 means the scan starts at channel 0.
- Simultaneous drain and load in the same cycle gives back-to-back beats with no bubble.
- A mode or sel change applies to the next grant only. A beat already in the register is unaffected.
- Reset:
  - out_valid = 0, out_data = 0, out_ch = 0
  - ptr = NCH-1, so the first round-robin grant favours channel 0
  - in_ready is 0 during reset
- Reset asserted mid-transfer discards the held beat. No input beat is accepted in the reset cycle.

## Timing
- Latency: an input beat accepted at edge k appears on out_data after edge k, and is visible in cycle k+1.
- Throughput: 1 beat per cycle while out_ready = 1.
- Combinational path: in_valid/sel/mode/out_ready -> in_ready. There is no path from in_data to out_data.
- Fairness: in round-robin mode with all channels valid and out_ready = 1, each channel is granted exactly once per NCH cycles.

## Configuration
- CHAN_ARB_MUX_LOCK_EN defined:
  - Adds ports in_last (input, NCH) and out_last (output, 1; registered with the data, reset 0).
  - Round-robin mode: once channel c is granted a beat with in_last[c] = 0, grant is locked to c until a beat with in_last[c] = 1 is accepted.
  - While locked, in_valid[c] = 0 gives no grant; the lock is not released.
  - The lock is cleared by reset.
  - Fixed mode ignores the lock but still forwards out_last.
- Not defined: no last ports. Arbitration is per beat.

## Test plan
- Fixed mode, NCH=8, WIDTH=3, all in_valid = 1, in_data[i] = i, sel = 5, out_ready = 1 -> out_data = 5, out_ch = 5 one cycle after the first edge; only in_ready[5] = 1.
- Round-robin mode, all valid, out_ready = 1, after reset -> out_ch sequence 0,1,2,…,7,0 with no bubbles.
- Round-robin mode, only channels 2 and 6 valid -> alternating 2,6,2,6; channels 0, 1, 3, 4, 5 and 7 never get in_ready.
- Back-pressure: out_ready = 0 for 3 cycles with a beat held -> out_data and out_ch stable, all in_ready = 0; at release, the next beat loads in the same cycle.
- Reset mid-stream: assert rst_n = 0 with out_valid = 1 -> next cycle out_valid = 0, out_data = 0; first grant after release goes to channel 0.
- LOCK_EN: channel 1 sends 3 beats with last on the third while channel 4 is valid -> out_ch = 1,1,1,4.
